pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_if.sv | 39 +++
 rtl/pc_unit.sv | 164 ++++++++++++++++
 tb/tb_pc_unit.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// ---------------------------------------------------------------------------
// pc_unit_if -- bus between the control/datapath and the PC unit.
//
// Signals (directions as seen by the pc_unit, i.e. the slave modport):
//   stall         in   1  hold PC and all internal state
//   NPCOp         in   4  next-PC operation from the control unit
//   imm16         in  16  instruction[15:0], branch offset in words
//   imm26         in  26  instruction[25:0], jump index
//   rs_data       in  32  GPR[rs] read value
//   rt_data       in  32  GPR[rt] read value
//   PC            out 32  current fetch address (registered)
//   link_addr     out 32  return address for JAL/JALR (combinational)
//   taken         out  1  current NPCOp redirects fetch (combinational)
//   in_delay_slot out  1  current PC is a branch delay slot (registered)
//
// The master modport is the driving side (control unit or testbench).
// ---------------------------------------------------------------------------
interface pc_unit_if;
    logic        stall;
    logic [3:0]  NPCOp;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] PC;
    logic [31:0] link_addr;
    logic        taken;
    logic        in_delay_slot;

    modport master (
        output stall, NPCOp, imm16, imm26, rs_data, rt_data,
        input  PC, link_addr, taken, in_delay_slot
    );

    modport slave (
        input  stall, NPCOp, imm16, imm26, rs_data, rt_data,
        output PC, link_addr, taken, in_delay_slot
    );
endinterface

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- MIPS-style program counter and next-PC selection.
//
// Ports:
//   clk  in  1  single clock, all state updates on the rising edge
//   rst  in  1  synchronous active-high reset, overrides stall
//   bus  pc_unit_if.slave  (stall, NPCOp, imm16, imm26, rs_data, rt_data in;
//                           PC, link_addr, taken, in_delay_slot out)
//
// Parameter:
//   RESET_PC  PC value loaded on reset (default 32'h0000_3000)
//
// Compile option:
//   BRANCH_DELAY_SLOT_EN  when defined, a redirect takes effect one
//   instruction late: the instruction after a taken branch/jump (the delay
//   slot) is always fetched, and its own NPCOp is ignored. Implemented as a
//   two-state IDLE/PENDING FSM holding the captured target in tgt_q. When
//   undefined, a taken redirect loads the target on the very next edge.
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic       clk,
    input logic       rst,
    pc_unit_if.slave  bus
);

    typedef enum logic [3:0] {
        OP_PLUS4       = 4'd0,
        OP_BRANCH_BEQ  = 4'd1,
        OP_BRANCH_BNE  = 4'd2,
        OP_BRANCH_BLEZ = 4'd3,
        OP_BRANCH_BGTZ = 4'd4,
        OP_BRANCH_BLTZ = 4'd5,
        OP_BRANCH_BGEZ = 4'd6,
        OP_JUMP        = 4'd7,
        OP_JUMPR       = 4'd8
    } npc_op_e;

    logic [31:0] pc_q;
    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic [31:0] target;
    logic        rs_neg;
    logic        rs_zero;
    logic        redirect;

    // ------------------------------------------------------------------
    // Target arithmetic and branch conditions (shared by both builds)
    // ------------------------------------------------------------------
    assign pc4       = pc_q + 32'd4;
    assign br_target = pc4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign j_target  = {pc4[31:28], bus.imm26, 2'b00};
    assign jr_target = {bus.rs_data[31:2], 2'b00};

    // Signed compare against zero reduces to the sign bit and a zero test.
    assign rs_neg  = bus.rs_data[31];
    assign rs_zero = (bus.rs_data == 32'd0);

    // redirect: would the current NPCOp change the fetch stream, ignoring
    // delay-slot state. Unlisted codes (9-15) fall to the default as PLUS4.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first,
        // otherwise an incomplete case infers a latch.
        redirect = 1'b0;
        target   = br_target;
        case (npc_op_e'(bus.NPCOp))
            OP_BRANCH_BEQ:  redirect = (bus.rs_data == bus.rt_data);
            OP_BRANCH_BNE:  redirect = (bus.rs_data != bus.rt_data);
            OP_BRANCH_BLEZ: redirect = rs_neg | rs_zero;
            OP_BRANCH_BGTZ: redirect = ~rs_neg & ~rs_zero;
            OP_BRANCH_BLTZ: redirect = rs_neg;
            OP_BRANCH_BGEZ: redirect = ~rs_neg;
            OP_JUMP: begin
                redirect = 1'b1;
                target   = j_target;
            end
            OP_JUMPR: begin
                redirect = 1'b1;
                target   = jr_target;
            end
            default: ;
        endcase
    end

    assign bus.PC = pc_q;

`ifdef BRANCH_DELAY_SLOT_EN
    // ------------------------------------------------------------------
    // Delay-slot build: IDLE -> (taken) -> PENDING -> IDLE
    // ------------------------------------------------------------------
    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_e;

    state_e      state_q;
    state_e      state_d;
    logic [31:0] pc_d;
    logic [31:0] tgt_q;
    logic [31:0] tgt_d;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            // NOTE: tgt_q is reset too; it is only read in PENDING, but a
            // defined value keeps simulation free of X and costs nothing.
            tgt_q   <= '0;
        end else if (!bus.stall) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    // Next-state logic. In PENDING the delay-slot instruction's NPCOp is
    // ignored: the PC goes to the captured target regardless.
    always_comb begin
        state_d = state_q;
        pc_d    = pc4;
        tgt_d   = tgt_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    tgt_d   = target;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                pc_d    = tgt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic. The delay slot itself never redirects, and the return
    // address skips over the delay slot.
    always_comb begin
        bus.taken         = redirect && (state_q == IDLE);
        bus.in_delay_slot = (state_q == PENDING);
        bus.link_addr     = pc_q + 32'd8;
    end
`else
    // ------------------------------------------------------------------
    // Default build: redirect on the next unstalled edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (!bus.stall) begin
            pc_q <= redirect ? target : pc4;
        end
    end

    assign bus.taken         = redirect;
    assign bus.in_delay_slot = 1'b0;
    assign bus.link_addr     = pc4;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- self-checking bench for pc_unit.
//
// A driver applies one instruction's worth of inputs per cycle and pushes the
// reference model's expected outputs for that cycle into a scoreboard queue;
// a monitor pops and compares on every falling edge. The reference model
// tracks the PC and a queue of pending redirect targets with plain
// arithmetic. Directed scenarios also compare against literal addresses.
// Build with +define+BRANCH_DELAY_SLOT_EN to exercise the delay-slot build.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_unit_if bus ();

    pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        ds;
        logic        taken;
        logic [31:0] link;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_tgt[$];   // pending redirect targets (delay-slot build)

    // What the current cycle's inputs will do at the next edge.
    logic        cur_taken;
    logic [31:0] cur_target;
    logic        cur_stall;
    logic        cur_rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit redirects(input logic [3:0] op, input logic [31:0] rs,
                                     input logic [31:0] rt);
        int s;
        s = int'(rs);
        case (op)
            4'd1:       return rs == rt;
            4'd2:       return rs != rt;
            4'd3:       return s <= 0;
            4'd4:       return s > 0;
            4'd5:       return s < 0;
            4'd6:       return s >= 0;
            4'd7, 4'd8: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] target_of(input logic [3:0] op, input logic [31:0] pc,
                                              input logic [15:0] i16, input logic [25:0] i26,
                                              input logic [31:0] rs);
        logic [31:0] next;
        next = pc + 32'd4;
        case (op)
            4'd7:    return (next & 32'hF000_0000) | (32'(i26) * 32'd4);
            4'd8:    return rs & ~32'h3;
            default: return next + 32'(int'($signed(i16)) * 4);
        endcase
    endfunction

    // Apply inputs for one cycle and push the expected outputs.
    task automatic set_in(input logic [3:0] op, input logic [15:0] i16, input logic [25:0] i26,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic st, input logic r);
        exp_t e;
        bit   pend;
        bus.NPCOp   = op;
        bus.imm16   = i16;
        bus.imm26   = i26;
        bus.rs_data = rs;
        bus.rt_data = rt;
        bus.stall   = st;
        rst         = r;
        pend        = (m_tgt.size() != 0);
        cur_taken   = !pend && redirects(op, rs, rt);
        cur_target  = target_of(op, m_pc, i16, i26, rs);
        cur_stall   = st;
        cur_rst     = r;
        e.pc    = m_pc;
        e.ds    = pend;
        e.taken = cur_taken;
        e.link  = m_pc + (DS ? 32'd8 : 32'd4);
        sb.push_back(e);
    endtask

    // Advance one edge and update the model.
    task automatic tick();
        @(posedge clk);
        if (cur_rst) begin
            m_pc = RESET_PC;
            m_tgt.delete();
        end else if (!cur_stall) begin
            if (DS) begin
                if (m_tgt.size() != 0) begin
                    m_pc = m_tgt.pop_front();
                end else begin
                    if (cur_taken) m_tgt.push_back(cur_target);
                    m_pc = m_pc + 32'd4;
                end
            end else begin
                m_pc = cur_taken ? cur_target : m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic plus4();
        set_in(4'd0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_pc",            bus.PC,               e.pc);
                check("sb_in_delay_slot", 32'(bus.in_delay_slot), 32'(e.ds));
                check("sb_taken",         32'(bus.taken),       32'(e.taken));
                check("sb_link_addr",     bus.link_addr,        e.link);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_hold;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pool [6];

        // Reset with stall also high: reset must win.
        rst         = 1'b1;
        bus.stall   = 1'b1;
        bus.NPCOp   = 4'd0;
        bus.imm16   = 16'h0;
        bus.imm26   = 26'h0;
        bus.rs_data = 32'h0;
        bus.rt_data = 32'h0;
        @(posedge clk);
        #1;
        m_pc = RESET_PC;
        m_tgt.delete();
        check("reset_pc", bus.PC, 32'h0000_3000);
        check("reset_ds", 32'(bus.in_delay_slot), 32'd0);

        // Backward BEQ from 0x3010.
        repeat (4) plus4();
        check("beq_start_pc", bus.PC, 32'h0000_3010);
        set_in(4'd1, 16'hFFFC, 26'h0, 32'd5, 32'd5, 1'b0, 1'b0);
        #1 check("beq_taken", 32'(bus.taken), 32'd1);
        tick();
`ifdef BRANCH_DELAY_SLOT_EN
        check("beq_slot_pc", bus.PC, 32'h0000_3014);
        // Delay-slot NPCOp is a jump here; it must be ignored.
        set_in(4'd7, 16'h0, 26'h3FF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 check("beq_slot_taken", 32'(bus.taken), 32'd0);
        tick();
`endif
        check("beq_pc", bus.PC, 32'h0000_3004);

        // Signed BLTZ from 0x3000.
        set_in(4'd0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        set_in(4'd5, 16'h0002, 26'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
        #1 check("bltz_taken", 32'(bus.taken), 32'd1);
        tick();
`ifdef BRANCH_DELAY_SLOT_EN
        plus4();
`endif
        check("bltz_pc", bus.PC, 32'h0000_300C);

        // JAL from 0x3000.
        set_in(4'd0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        set_in(4'd7, 16'h0, 26'h000_0C40, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef BRANCH_DELAY_SLOT_EN
        #1 check("jal_link", bus.link_addr, 32'h0000_3008);
        tick();
        plus4();
`else
        #1 check("jal_link", bus.link_addr, 32'h0000_3004);
        tick();
`endif
        check("jal_pc", bus.PC, 32'h0000_3100);

        // JUMPR under stall for two edges.
        pc_hold = bus.PC;
        set_in(4'd8, 16'h0, 26'h0, 32'h0000_4003, 32'h0, 1'b1, 1'b0);
        #1 check("jr_taken_stalled", 32'(bus.taken), 32'd1);
        tick();
        check("jr_hold1", bus.PC, 32'h0000_3100);
        set_in(4'd8, 16'h0, 26'h0, 32'h0000_4003, 32'h0, 1'b1, 1'b0);
        tick();
        check("jr_hold2", bus.PC, pc_hold);
        set_in(4'd8, 16'h0, 26'h0, 32'h0000_4003, 32'h0, 1'b0, 1'b0);
        tick();
`ifdef BRANCH_DELAY_SLOT_EN
        check("jr_slot_ds", 32'(bus.in_delay_slot), 32'd1);
        plus4();
`endif
        check("jr_pc", bus.PC, 32'h0000_4000);

        // 32-bit wrap.
        set_in(4'd8, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        tick();
`ifdef BRANCH_DELAY_SLOT_EN
        plus4();
`endif
        check("wrap_start_pc", bus.PC, 32'hFFFF_FFFC);
        plus4();
        check("wrap_pc", bus.PC, 32'h0000_0000);

        // Taken branch followed by reset: any captured target is dropped.
        set_in(4'd1, 16'h0010, 26'h0, 32'd7, 32'd7, 1'b0, 1'b0);
        tick();
`ifdef BRANCH_DELAY_SLOT_EN
        check("pend_ds", 32'(bus.in_delay_slot), 32'd1);
`endif
        set_in(4'd0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        check("pend_rst_pc", bus.PC, 32'h0000_3000);
        check("pend_rst_ds", 32'(bus.in_delay_slot), 32'd0);
        plus4();
        check("pend_discard_pc", bus.PC, 32'h0000_3004);

        // Randomized traffic.
        pool[0] = 32'h0000_0000;
        pool[1] = 32'h0000_0001;
        pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000;
        pool[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 400; i++) begin
            pool[5] = $urandom;
            rs = pool[$urandom_range(0, 5)];
            rt = ($urandom_range(0, 1) == 0) ? rs : pool[$urandom_range(0, 5)];
            set_in(4'($urandom_range(0, 15)), 16'($urandom), 26'($urandom), rs, rt,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);
            tick();
        end

        // Let the monitor drain the last record.
        bus.stall = 1'b1;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
